// File: rtl/cnt3_arbiter.sv
// -----------------------------------------------------------------------------
// cnt3_arbiter
// Round-robin arbiter/sequencer sharing one 3-bit loadable, saturating counter
// between two requesters. Grants the counter, loads the winner's start value,
// steps the counter until its carry-out rises (or a timeout expires), pulses a
// per-requester done and releases the counter.
//
// Ports
//   clk            : clock, rising-edge active
//   rst            : asynchronous reset, active high
//   req0, req1     : level-sensitive service requests, held until done
//   init_a, init_b : counter start values for requester 0 / requester 1
//   co             : carry-out of the shared counter (counter at all ones)
//   ld_cnt         : counter load strobe (LOAD only)
//   cnt            : counter count enable (COUNT only, suppressed once co=1)
//   init0          : value presented to the counter load input
//   gnt0, gnt1     : grant, one-hot or zero
//   done0, done1   : one-cycle completion pulse to the granted requester
//   busy           : high in every state except IDLE
//   err            : one-cycle pulse with done when the timeout aborted the op
// -----------------------------------------------------------------------------
module cnt3_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic [2:0] init_a,
   input  logic [2:0] init_b,
   input  logic       co,
   output logic       ld_cnt,
   output logic       cnt,
   output logic [2:0] init0,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic       busy,
   output logic       err
);

   localparam int unsigned INIT_W = 3;
   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COUNT  = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                owner;
   logic                last;
   logic                err_flag;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [INIT_W-1:0]   init_q;

   logic                any_req;
   logic                win;
   logic                wait_end;
   logic                count_exit;

   // Arbitration: a lone request wins; on a tie the requester that was not
   // served last wins.
   always_comb begin
      any_req = req0 | req1;
      win     = 1'b0;
      if (req0 && req1) begin
         win = ~last;
      end else if (req1) begin
         win = 1'b1;
      end
   end

   assign wait_end   = (wait_cnt == WAIT_W'(TIMEOUT - 1));
   assign count_exit = co | wait_end;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and output decode.
   always_comb begin
      state_nxt = state;
      ld_cnt    = 1'b0;
      cnt       = 1'b0;
      init0     = '0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      done0     = 1'b0;
      done1     = 1'b0;
      busy      = 1'b0;
      err       = 1'b0;

      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            state_nxt = COUNT;
            ld_cnt    = 1'b1;
            init0     = init_q;
            gnt0      = ~owner;
            gnt1      = owner;
            busy      = 1'b1;
         end
         COUNT: begin
            if (count_exit) begin
               state_nxt = FINISH;
            end
            // Never enable a saturated counter.
            cnt   = ~co;
            init0 = init_q;
            gnt0  = ~owner;
            gnt1  = owner;
            busy  = 1'b1;
         end
         FINISH: begin
            state_nxt = IDLE;
            init0     = init_q;
            gnt0      = ~owner;
            gnt1      = owner;
            done0     = ~owner;
            done1     = owner;
            err       = err_flag;
            busy      = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Owner/init capture, timeout counter and round-robin history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner    <= 1'b0;
         last     <= 1'b1;
         err_flag <= 1'b0;
         wait_cnt <= '0;
         init_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner  <= win;
                  init_q <= win ? init_b : init_a;
               end
            end
            LOAD: begin
               wait_cnt <= '0;
               err_flag <= 1'b0;
            end
            COUNT: begin
               wait_cnt <= wait_cnt + WAIT_W'(1);
               if (count_exit) begin
                  last     <= owner;
                  // co wins over a simultaneous timeout.
                  err_flag <= ~co;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cnt3_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cnt3_arbiter
// Self-checking bench for cnt3_arbiter. A behavioural model of the shared
// 3-bit saturating counter closes the loop; expected transactions are queued
// when requests are driven and compared when the DUT pulses done.
// -----------------------------------------------------------------------------
module tb_cnt3_arbiter;

   localparam int unsigned TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0 = 1'b0;
   logic       req1 = 1'b0;
   logic [2:0] init_a = 3'd0;
   logic [2:0] init_b = 3'd0;
   logic       co;
   logic       ld_cnt;
   logic       cnt;
   logic [2:0] init0;
   logic       gnt0;
   logic       gnt1;
   logic       done0;
   logic       done1;
   logic       busy;
   logic       err;

   logic       co_stuck = 1'b0;
   logic [2:0] cval;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int who;
      int init;
      int glen;
      int ncnt;
      int err;
   } txn_t;

   txn_t sb[$];

   cnt3_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0),
      .req1   (req1),
      .init_a (init_a),
      .init_b (init_b),
      .co     (co),
      .ld_cnt (ld_cnt),
      .cnt    (cnt),
      .init0  (init0),
      .gnt0   (gnt0),
      .gnt1   (gnt1),
      .done0  (done0),
      .done1  (done1),
      .busy   (busy),
      .err    (err)
   );

   always #5 clk = ~clk;

   // Shared counter model: loadable, saturating at 7, co = all ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cval <= 3'd0;
      end else if (ld_cnt) begin
         cval <= init0;
      end else if (cnt && cval != 3'd7) begin
         cval <= 3'(cval + 3'd1);
      end
   end

   assign co = co_stuck ? 1'b0 : (cval == 3'd7);

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int all_outs();
      return int'({ld_cnt, cnt, init0, gnt0, gnt1, done0, done1, busy, err});
   endfunction

   // Expected transaction straight from the timing rules: grant = 10-init
   // cycles, cnt high 7-init cycles; a timeout gives LOAD+TIMEOUT+FINISH.
   function automatic txn_t exp_txn(input int who, input int init, input bit tmo);
      txn_t t;
      t.who  = who;
      t.init = init;
      t.glen = tmo ? int'(TIMEOUT) + 2 : 10 - init;
      t.ncnt = tmo ? int'(TIMEOUT) : 7 - init;
      t.err  = tmo ? 1 : 0;
      return t;
   endfunction

   // Transaction monitor.
   bit   active    = 1'b0;
   bit   prev_gnt  = 1'b0;
   bit   after_don = 1'b0;
   bit   ld_first  = 1'b0;
   bit   init_ok   = 1'b0;
   int   m_who     = 0;
   int   m_glen    = 0;
   int   m_ncnt    = 0;
   int   m_load    = 0;

   always @(negedge clk) begin
      if (rst) begin
         active    = 1'b0;
         prev_gnt  = 1'b0;
         after_don = 1'b0;
      end else begin
         check_eq("gnt_onehot", int'(gnt0 & gnt1), 0);
         check_eq("err_outside_done", int'(err & ~(done0 | done1)), 0);
         if (after_don) begin
            check_eq("busy_after_done", int'(busy | gnt0 | gnt1), 0);
            after_don = 1'b0;
         end
         if ((gnt0 | gnt1) && !active) begin
            check_eq("idle_gap", int'(prev_gnt), 0);
            active   = 1'b1;
            m_who    = int'(gnt1);
            m_glen   = 0;
            m_ncnt   = 0;
            m_load   = int'(init0);
            ld_first = ld_cnt;
            init_ok  = 1'b1;
         end
         if (active) begin
            m_glen++;
            if (cnt) m_ncnt++;
            if (int'(init0) != m_load) init_ok = 1'b0;
            if (done0 | done1) begin
               txn_t e;
               check_eq("done_owner", int'(done1), m_who);
               if (sb.size() == 0) begin
                  check_eq("unexpected_done", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check_eq("who", m_who, e.who);
                  check_eq("init0_load", m_load, e.init);
                  check_eq("gnt_len", m_glen, e.glen);
                  check_eq("cnt_cycles", m_ncnt, e.ncnt);
                  check_eq("err", int'(err), e.err);
                  check_eq("ld_first_cycle", int'(ld_first), 1);
                  check_eq("init0_held", int'(init_ok), 1);
               end
               active    = 1'b0;
               after_don = 1'b1;
            end
         end
         prev_gnt = gnt0 | gnt1;
      end
   end

   task automatic wait_done(input int who, input bit drop, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if ((who == 0 && done0) || (who == 1 && done1)) seen = 1'b1;
      end
      check_eq("done_seen", int'(seen), 1);
      if (seen && drop) begin
         if (who == 0) req0 = 1'b0;
         else          req1 = 1'b0;
      end
   endtask

   task automatic wait_count0(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (gnt0 && !ld_cnt && !done0) seen = 1'b1;
      end
      check_eq("reach_count", int'(seen), 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      // Reset with req0 pending: outputs quiet, then gnt0 on the first edge.
      req0   = 1'b1;
      init_a = 3'd3;
      #1 rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check_eq("rst_outputs", all_outs(), 0);
      end
      sb.push_back(exp_txn(0, 3, 1'b0));
      #2 rst = 1'b0;
      @(posedge clk);
      #1 check_eq("gnt0_after_rst", int'(gnt0), 1);
      wait_done(0, 1'b1, 20);
      repeat (2) @(negedge clk);

      // Tie from reset: 0 first, then 1, then 0 again.
      do_reset();
      init_a = 3'd7;
      init_b = 3'd5;
      req0   = 1'b1;
      req1   = 1'b1;
      sb.push_back(exp_txn(0, 7, 1'b0));
      sb.push_back(exp_txn(1, 5, 1'b0));
      sb.push_back(exp_txn(0, 7, 1'b0));
      wait_done(0, 1'b0, 20);
      wait_done(1, 1'b1, 20);
      wait_done(0, 1'b1, 20);
      repeat (2) @(negedge clk);

      // Saturated init: no cnt at all.
      init_b = 3'd7;
      req1   = 1'b1;
      sb.push_back(exp_txn(1, 7, 1'b0));
      wait_done(1, 1'b1, 20);
      repeat (2) @(negedge clk);

      // Timeout with co stuck low.
      co_stuck = 1'b1;
      init_a   = 3'd2;
      req0     = 1'b1;
      sb.push_back(exp_txn(0, 2, 1'b1));
      wait_done(0, 1'b1, 40);
      @(negedge clk);
      co_stuck = 1'b0;
      repeat (2) @(negedge clk);

      // Reset in the middle of COUNT: immediate silence, no done.
      init_a = 3'd1;
      req0   = 1'b1;
      wait_count0(20);
      @(negedge clk);
      #2 rst = 1'b1;
      req0 = 1'b0;
      #1 check_eq("rst_mid_count", int'({gnt0, gnt1, busy, cnt, done0, done1, err, ld_cnt}), 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);

      // Late request waits for IDLE; req0 dropped and init changed mid-op.
      init_a = 3'd3;
      req0   = 1'b1;
      sb.push_back(exp_txn(0, 3, 1'b0));
      wait_count0(20);
      init_b = 3'd6;
      req1   = 1'b1;
      sb.push_back(exp_txn(1, 6, 1'b0));
      init_a = 3'd5;
      req0   = 1'b0;
      wait_done(0, 1'b0, 20);
      wait_done(1, 1'b1, 20);
      repeat (3) @(negedge clk);

      check_eq("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
